// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debouncer: per-channel FSM state encodings
// and the counter-width helper used by every channel.
package key_debounce_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    // Width able to hold the largest of the three cycle counts without wrapping.
    function automatic int cnt_width(input int db_cycles, input int rep_delay, input int rep_period);
        int max_v;
        max_v = db_cycles;
        if (rep_delay > max_v) begin
            max_v = rep_delay;
        end else begin
            max_v = max_v;
        end
        if (rep_period > max_v) begin
            max_v = rep_period;
        end else begin
            max_v = max_v;
        end
        return $clog2(max_v + 32'sd1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchronizer, press/release debounce FSM,
// and an auto-repeat generator active while the key is held.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DB_CYCLES      = 250000,
    parameter int REPEAT_DELAY   = 6250000,
    parameter int REPEAT_PERIOD  = 1250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic level_o,
    output logic press_tick_o,
    output logic release_tick_o,
    output logic repeat_tick_o
);

    localparam int CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic             REPEAT_EN = (REPEAT_DELAY != 0);
    localparam logic             INVERT    = (KEY_ACTIVE_LOW != 0);

    // The polarity flip is a single inverter ahead of the synchronizer so that
    // the cleared synchronizer value (0) always means "not pressed".
    logic             key_norm_s;
    logic [1:0]       sync_q;
    logic             pressed_s;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] db_cnt_q,    db_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q,   rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;   // 0: waiting first delay, 1: periodic
    logic             level_q,     level_d;
    logic             press_q,     press_d;
    logic             release_q,   release_d;
    logic             repeat_q,    repeat_d;
    logic [CNT_W-1:0] rep_target_s;

    assign key_norm_s   = key_i ^ INVERT;
    assign pressed_s    = sync_q[1];
    assign rep_target_s = rep_phase_q ? REP_NEXT : REP_FIRST;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_norm_s};
        end
    end

    // Next-state logic for the debounce FSM, both counters and the tick outputs.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed_s) begin
                    state_d  = ST_WAIT_PRESS;
                    db_cnt_d = CNT_ZERO;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT_PRESS: begin
                if (!pressed_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = CNT_ZERO;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = ST_PRESSED;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    rep_cnt_d   = CNT_ZERO;
                    rep_phase_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    state_d  = ST_WAIT_RELEASE;
                    db_cnt_d = CNT_ZERO;
                end else if (REPEAT_EN) begin
                    if (rep_cnt_q == rep_target_s) begin
                        repeat_d    = 1'b1;
                        rep_cnt_d   = CNT_ZERO;
                        rep_phase_d = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + CNT_ONE;
                    end
                end else begin
                    rep_cnt_d = rep_cnt_q;
                end
            end
            ST_WAIT_RELEASE: begin
                // Repeat counter holds here so a bounce resumes the cadence.
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered-output update with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= CNT_ZERO;
            rep_cnt_q   <= CNT_ZERO;
            rep_phase_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign level_o        = level_q;
    assign press_tick_o   = press_q;
    assign release_tick_o = release_q;
    assign repeat_tick_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one independent key_debounce_ch per raw key input.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS         = 2,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int DB_CYCLES      = 250000,
    parameter int REPEAT_DELAY   = 6250000,
    parameter int REPEAT_PERIOD  = 1250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] press_tick,
    output logic [N_KEYS-1:0] release_tick,
    output logic [N_KEYS-1:0] repeat_tick
);

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
            .DB_CYCLES      (DB_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk_i          (clk),
            .rst_i          (rst),
            .key_i          (key[gi]),
            .level_o        (level[gi]),
            .press_tick_o   (press_tick[gi]),
            .release_tick_o (release_tick[gi]),
            .repeat_tick_o  (repeat_tick[gi])
        );
    end

endmodule
